// File: rtl/hex_scan_driver.sv
// -----------------------------------------------------------------------------
// hex_scan_driver
//
// Drives an 8-digit multiplexed, common-anode 7-segment display from a 32-bit
// word. Nibble k is shown on digit k (digit 0 = rightmost). The word is copied
// into a shadow register on the first clock after reset and then only at frame
// ends, so one frame never mixes old and new nibbles.
//
// Parameters:
//   DIGIT_PERIOD  clock cycles each digit stays lit (>= 2)
//   NUM_DIGITS    digits scanned; fixed at 8 (32-bit word, 4 bits per digit)
//
// Ports:
//   clk_i         system clock
//   reset         asynchronous, active-high reset
//   hex_dec_i     value to display
//   an_o          digit anode enables, active-low, one-hot-low
//   seg_o         segments {g,f,e,d,c,b,a}, active-low
//   frame_done_o  one-cycle pulse when the shadow reloads at a frame end
//
// Optional feature (compile-time macro HEX_LEADING_ZERO_BLANK_EN):
//   When defined, digits above the most significant non-zero nibble of the
//   shadow are blanked (an_o = 8'hFF, seg_o = 7'h7F) for their whole dwell.
//   Digit 0 is never blanked. Scan timing is identical either way.
// -----------------------------------------------------------------------------
module hex_scan_driver #(
    parameter int DIGIT_PERIOD = 100000,
    parameter int NUM_DIGITS   = 8
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [31:0] hex_dec_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        frame_done_o
);

    // Guard against a 0-bit counter when DIGIT_PERIOD is at its minimum.
    localparam int PW = (DIGIT_PERIOD > 2) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [PW-1:0] TC = PW'(DIGIT_PERIOD - 1);

    logic [PW-1:0] prescaler;
    logic [2:0]    index;
    logic [31:0]   shadow;
    logic          load_first;

    logic          tc;
    logic          frame_end;
    logic [3:0]    cur_nib;
    logic          blank;

    assign tc        = (prescaler == TC);
    assign frame_end = tc && (index == 3'd7);
    assign cur_nib   = shadow[{index, 2'b00} +: 4];

`ifdef HEX_LEADING_ZERO_BLANK_EN
    // Position of the most significant non-zero nibble; 0 when shadow is 0,
    // which keeps digit 0 lit so an all-zero word still shows a single "0".
    logic [2:0] lead;

    always_comb begin
        lead = 3'd0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (shadow[4*k +: 4] != 4'h0)
                lead = 3'(k);
        end
    end

    assign blank = (index > lead);
`else
    assign blank = 1'b0;
`endif

    // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Outputs are registered from the pre-edge index/shadow, so the display
    // lags the scan state by one cycle; each digit still gets exactly
    // DIGIT_PERIOD consecutive cycles with no gaps.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            prescaler    <= '0;
            index        <= 3'd0;
            shadow       <= 32'h0;
            load_first   <= 1'b1;
            an_o         <= 8'hFF;
            seg_o        <= 7'h7F;
            frame_done_o <= 1'b0;
        end else begin
            prescaler <= tc ? '0 : prescaler + 1'b1;
            if (tc)
                index <= index + 3'd1;

            // load_first cannot coincide with frame_end: the prescaler is 0
            // on the first edge and TC is at least 1.
            load_first <= 1'b0;
            if (load_first || frame_end)
                shadow <= hex_dec_i;

            frame_done_o <= frame_end;

            if (blank) begin
                an_o  <= 8'hFF;
                seg_o <= 7'h7F;
            end else begin
                an_o  <= ~(8'd1 << index);
                seg_o <= decode(cur_nib);
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_driver.sv
// -----------------------------------------------------------------------------
// Bench for hex_scan_driver with DIGIT_PERIOD = 4.
// The reference model works from the edge count n since reset release:
//   edge n shows digit ((n-1)/P) mod 8 of the word of frame (n-1)/(8P);
//   frame 0's word is the input sampled at edge 1 (edge 1 itself still shows
//   the reset shadow of 0), frame f>0's word is sampled at edge 8P*f, and
//   frame_done is seen after every edge that is a multiple of 8P.
// -----------------------------------------------------------------------------
module tb_hex_scan_driver;

    localparam int P     = 4;
    localparam int FRAME = 8 * P;

    logic        clk_i = 1'b0;
    logic        reset;
    logic [31:0] hex_dec_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        frame_done_o;

    int          n = 0;
    logic [31:0] cap [512];
    logic [6:0]  seg_tab [16];
    logic [6:0]  fedc_seg [8];
    int          vectors = 0;
    int          miscompares = 0;

    hex_scan_driver #(.DIGIT_PERIOD(P), .NUM_DIGITS(8)) dut (
        .clk_i        (clk_i),
        .reset        (reset),
        .hex_dec_i    (hex_dec_i),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .frame_done_o (frame_done_o)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        fedc_seg = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    // Edge counter and frame-word capture.
    initial forever begin
        @(posedge clk_i);
        if (reset) begin
            n = 0;
        end else begin
            n = n + 1;
            if (n == 1)
                cap[0] = hex_dec_i;
            else if (n % FRAME == 0)
                cap[(n / FRAME) % 512] = hex_dec_i;
        end
    end

    task automatic model(input int e, output logic [7:0] e_an,
                         output logic [6:0] e_seg, output logic e_fd);
        int          d;
        int          lead;
        logic [31:0] val;
        d    = ((e - 1) / P) % 8;
        val  = (e == 1) ? 32'h0 : cap[((e - 1) / FRAME) % 512];
        lead = 0;
        for (int k = 1; k < 8; k++)
            if (val[4*k +: 4] != 4'h0) lead = k;
        e_fd  = (e % FRAME == 0);
        e_an  = ~(8'd1 << d);
        e_seg = seg_tab[val[4*d +: 4]];
`ifdef HEX_LEADING_ZERO_BLANK_EN
        if (d > lead) begin
            e_an  = 8'hFF;
            e_seg = 7'h7F;
        end
`endif
    endtask

    // Per-cycle compare against the model.
    initial forever begin
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_fd;
        @(negedge clk_i);
        if (reset || n == 0) begin
            e_an = 8'hFF; e_seg = 7'h7F; e_fd = 1'b0;
        end else begin
            model(n, e_an, e_seg, e_fd);
        end
        vectors++;
        if (an_o !== e_an || seg_o !== e_seg || frame_done_o !== e_fd) begin
            miscompares++;
            $display("FAIL model n=%0d: got an=%h seg=%h fd=%b, want an=%h seg=%h fd=%b",
                     n, an_o, seg_o, frame_done_o, e_an, e_seg, e_fd);
        end
    end

    task automatic pin(input string name, input logic [7:0] e_an, input logic [6:0] e_seg);
        vectors++;
        if (an_o !== e_an || seg_o !== e_seg) begin
            miscompares++;
            $display("FAIL %s n=%0d: got an=%h seg=%h, want an=%h seg=%h",
                     name, n, an_o, seg_o, e_an, e_seg);
        end
    endtask

    task automatic pin_fd(input string name, input logic e_fd);
        vectors++;
        if (frame_done_o !== e_fd) begin
            miscompares++;
            $display("FAIL %s n=%0d: got fd=%b, want fd=%b", name, n, frame_done_o, e_fd);
        end
    endtask

    task automatic wait_n(input int target);
        int budget;
        budget = 5000;
        while (n < target && budget > 0) begin
            @(negedge clk_i);
            budget--;
        end
        if (n != target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_n: reached n=%0d, want n=%0d", n, target);
        end
    endtask

    initial begin
        reset     = 1'b1;
        hex_dec_i = 32'h01234567;
        repeat (3) @(negedge clk_i);
        pin("reset_state", 8'hFF, 7'h7F);
        reset = 1'b0;

        // First frame: reset shadow on cycle 1, then the loaded word.
        wait_n(1);  pin("first_cycle", 8'hFE, 7'h40);
        wait_n(2);  pin("digit0_loaded", 8'hFE, 7'h78);
        wait_n(4);  pin("digit0_last", 8'hFE, 7'h78);
        wait_n(5);  pin("digit1_first", 8'hFD, 7'h02);
        wait_n(29); pin("digit7", 8'h7F, 7'h40);
        wait_n(32); pin_fd("frame_done_hi", 1'b1);
        wait_n(33); pin_fd("frame_done_lo", 1'b0);
        pin("frame1_digit0", 8'hFE, 7'h78);

        // Word change while digit 3 is lit: rest of frame keeps old nibbles.
        wait_n(45); hex_dec_i = 32'hFFFFFFFF;
        wait_n(49); pin("old_digit4", 8'hEF, 7'h30);
        wait_n(61); pin("old_digit7", 8'h7F, 7'h40);
        wait_n(64); pin_fd("frame_done_2", 1'b1);
        wait_n(66); pin("new_digit0", 8'hFE, 7'h0E);
        wait_n(78); pin("new_digit3", 8'hF7, 7'h0E);

        // Random words, many with leading zero nibbles.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk_i);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 9) == 0)
                    hex_dec_i = 32'h0;
                else
                    hex_dec_i = $urandom & (32'hFFFFFFFF >> (4 * $urandom_range(0, 7)));
            end
        end

        // Asynchronous reset while digit 5 is displayed.
        begin
            int budget;
            budget = 200;
            while (((n - 1) / P) % 8 != 5 && budget > 0) begin
                @(negedge clk_i);
                budget--;
            end
            if (budget == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL find_digit5: n=%0d", n);
            end
        end
        #2 reset = 1'b1;
        #1 pin("async_reset", 8'hFF, 7'h7F);
        hex_dec_i = 32'hFEDCBA98;
        repeat (2) @(negedge clk_i);
        reset = 1'b0;

        // Decode check on a freshly loaded word.
        for (int k = 0; k < 8; k++) begin
            wait_n(P * k + 2);
            pin("decode_fedcba98", ~(8'd1 << k), fedc_seg[k]);
        end

        // Leading-zero handling.
        hex_dec_i = 32'h000000A5;
        wait_n(34); pin("a5_digit0", 8'hFE, 7'h12);
        wait_n(38); pin("a5_digit1", 8'hFD, 7'h08);
`ifdef HEX_LEADING_ZERO_BLANK_EN
        wait_n(42); pin("a5_digit2", 8'hFF, 7'h7F);
        wait_n(62); pin("a5_digit7", 8'hFF, 7'h7F);
`else
        wait_n(42); pin("a5_digit2", 8'hFB, 7'h40);
        wait_n(62); pin("a5_digit7", 8'h7F, 7'h40);
`endif
        hex_dec_i = 32'h0;
        wait_n(66); pin("zero_digit0", 8'hFE, 7'h40);
`ifdef HEX_LEADING_ZERO_BLANK_EN
        wait_n(70); pin("zero_digit1", 8'hFF, 7'h7F);
`else
        wait_n(70); pin("zero_digit1", 8'hFD, 7'h40);
`endif

        repeat (20) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
